uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter ACK_WAIT, default 4, clocks allowed for i_Busy to rise after a launch.
REQ-003 SHALL have port i_Clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port i_Rst_L  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_Byte  input  8  byte to enqueue.
REQ-006 SHALL have port i_Write  input  1  1-clock enqueue strobe from the receive side.
REQ-007 SHALL have port o_Full  output  1  queue holds DEPTH entries.
REQ-008 SHALL have port o_Empty  output  1  queue holds 0 entries.
REQ-009 SHALL have port o_Count  output  $clog2(DEPTH)+1  current occupancy.
REQ-010 SHALL have port o_Overflow  output  1  sticky: a write was dropped.
REQ-011 SHALL have port o_Ack_Timeout  output  1  sticky: encoder failed to assert busy.
REQ-012 SHALL have port o_Byte  output  8  byte presented to the UART encoder.
REQ-013 SHALL have port o_Write_Enable  output  1  1-clock launch pulse to the encoder.
REQ-014 SHALL have port i_Busy  input  1  encoder transmitting.

Function
REQ-015 SHALL store bytes in a circular buffer with read/write pointers wrapping modulo DEPTH.
REQ-016 SHALL accept i_Write only when o_Full is 0 that cycle; i_Write while full SHALL drop the byte and set o_Overflow, even if a pop occurs the same cycle.
REQ-017 SHALL update o_Count by +1 on push, -1 on pop, unchanged on simultaneous push and pop; o_Full/o_Empty SHALL derive from registered o_Count.
REQ-018 SHALL run FSM states IDLE, LAUNCH, WAIT_START, WAIT_DONE.
REQ-019 IDLE: if not empty and i_Busy is 0, pop head into o_Byte and go to LAUNCH.
REQ-020 LAUNCH: assert o_Write_Enable for exactly one clock, hold o_Byte stable, go to WAIT_START.
REQ-021 WAIT_START: i_Busy 1 goes to WAIT_DONE; after ACK_WAIT clocks without i_Busy, set o_Ack_Timeout and go to IDLE.
REQ-022 WAIT_DONE: stay while i_Busy is 1; on i_Busy 0 go to IDLE.
REQ-023 o_Byte SHALL remain unchanged from LAUNCH until the next pop.
REQ-024 Latency: a byte written into an empty queue with the encoder idle SHALL produce o_Write_Enable exactly 2 clocks after the i_Write cycle.
REQ-025 Back-to-back bytes SHALL launch no earlier than 1 clock after i_Busy falls.
REQ-026 Sticky flags SHALL clear only on reset.

Reset
REQ-027 While i_Rst_L is 0, the block SHALL asynchronously clear: pointers 0, o_Count 0, o_Empty 1, o_Full 0, o_Byte 8'h00, o_Write_Enable 0, o_Overflow 0, o_Ack_Timeout 0, FSM IDLE.
REQ-028 Reset mid-transmission SHALL discard all queued bytes and SHALL NOT emit o_Write_Enable until i_Rst_L is released and a new byte is written.
REQ-029 Memory contents need not be reset.

Structure
REQ-030 FSM state encodings and the default DEPTH SHALL live in a shared UART package alongside the baud-period constant (2604 clocks at 25 MHz / 9600 baud).
REQ-031 The storage/pointer logic SHALL be one sub-module, byte_fifo; the launch FSM SHALL sit in uart_tx_queue.

Verification
REQ-032 Reset, write 8'h41 with i_Busy 0 -> o_Write_Enable pulses 2 clocks later with o_Byte 8'h41; o_Count returns to 0.
REQ-033 Hold i_Busy 1, write 16 bytes 8'h00..8'h0F, then a 17th (8'hFF) -> o_Full 1, o_Overflow 1; after release, bytes 8'h00..8'h0F are launched in order and 8'hFF never appears.
REQ-034 With queue full, i_Write coincident with an IDLE pop -> byte dropped, o_Count 15, o_Overflow 1.
REQ-035 Encoder model never raises i_Busy after a launch -> o_Ack_Timeout 1 after 4 clocks in WAIT_START, FSM returns to IDLE and launches the next byte.
REQ-036 Drop i_Rst_L during WAIT_DONE with 5 bytes queued -> all outputs reach reset values immediately, and no o_Write_Enable occurs afterwards until a new write.
REQ-037 Pointer wrap: stream 40 bytes through a DEPTH=16 queue against an encoder busy for 2604×10 clocks -> output sequence equals input sequence, no flags set.

Source files
------------

// File: rtl/uart_tx_queue_pkg.sv
// Shared UART constants: launch FSM encoding, default queue depth and baud timing.
package uart_tx_queue_pkg;

   localparam int DEFAULT_DEPTH = 16;
   localparam int CLK_HZ        = 25_000_000;
   localparam int BAUD_RATE     = 9600;
   localparam int BAUD_PERIOD   = CLK_HZ / BAUD_RATE;   // 2604 clocks per bit
   localparam int FRAME_BITS    = 10;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_LAUNCH     = 2'b01,
      ST_WAIT_START = 2'b10,
      ST_WAIT_DONE  = 2'b11
   } tx_state_t;

endpackage

// File: rtl/uart_tx_queue_byte_fifo.sv
// Circular byte store with wrapping pointers, registered occupancy and sticky overflow.
module byte_fifo
   import uart_tx_queue_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst_L,
   input  logic [7:0]               i_Byte,
   input  logic                     i_Write,
   input  logic                     i_Pop,
   output logic [7:0]               o_Head,
   output logic                     o_Full,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Count,
   output logic                     o_Overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          overflow_r;
   logic          push_ok_s;
   logic          pop_ok_s;

   assign o_Full     = (count_r == (AW+1)'(DEPTH));
   assign o_Empty    = (count_r == (AW+1)'(0));
   assign o_Count    = count_r;
   assign o_Overflow = overflow_r;
   assign o_Head     = mem_r[rd_ptr_r];

   // A write while full is dropped even if a pop frees a slot that same cycle.
   assign push_ok_s = i_Write && !o_Full;
   assign pop_ok_s  = i_Pop && !o_Empty;

   // Storage array, intentionally without reset.
   always_ff @(posedge i_Clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= i_Byte;
      end
   end

   // Pointers, occupancy and sticky overflow.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         wr_ptr_r   <= AW'(0);
         rd_ptr_r   <= AW'(0);
         count_r    <= (AW+1)'(0);
         overflow_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
         if (i_Write && o_Full) begin
            overflow_r <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART encoder: pops one byte per frame, pulses the encoder
// and watches for its busy acknowledge.
module uart_tx_queue
   import uart_tx_queue_pkg::*;
#(
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int ACK_WAIT = 4
) (
   input  logic                     i_Clk,
   input  logic                     i_Rst_L,
   input  logic [7:0]               i_Byte,
   input  logic                     i_Write,
   output logic                     o_Full,
   output logic                     o_Empty,
   output logic [$clog2(DEPTH):0]   o_Count,
   output logic                     o_Overflow,
   output logic                     o_Ack_Timeout,
   output logic [7:0]               o_Byte,
   output logic                     o_Write_Enable,
   input  logic                     i_Busy
);

   localparam int AKW = (ACK_WAIT < 2) ? 1 : $clog2(ACK_WAIT);

   tx_state_t      state_r;
   logic [7:0]     byte_r;
   logic           we_r;
   logic           timeout_r;
   logic [AKW-1:0] ack_cnt_r;
   logic [7:0]     head_s;
   logic           pop_s;

   assign pop_s          = (state_r == ST_IDLE) && !o_Empty && !i_Busy;
   assign o_Byte         = byte_r;
   assign o_Write_Enable = we_r;
   assign o_Ack_Timeout  = timeout_r;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_Clk      (i_Clk),
      .i_Rst_L    (i_Rst_L),
      .i_Byte     (i_Byte),
      .i_Write    (i_Write),
      .i_Pop      (pop_s),
      .o_Head     (head_s),
      .o_Full     (o_Full),
      .o_Empty    (o_Empty),
      .o_Count    (o_Count),
      .o_Overflow (o_Overflow)
   );

   // Launch FSM; the enable pulse is registered alongside the entry into LAUNCH.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_r   <= ST_IDLE;
         byte_r    <= 8'h00;
         we_r      <= 1'b0;
         timeout_r <= 1'b0;
         ack_cnt_r <= AKW'(0);
      end else begin
         case (state_r)
            ST_IDLE: begin
               we_r <= 1'b0;
               if (pop_s) begin
                  byte_r  <= head_s;
                  we_r    <= 1'b1;
                  state_r <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               we_r      <= 1'b0;
               ack_cnt_r <= AKW'(0);
               state_r   <= ST_WAIT_START;
            end
            ST_WAIT_START: begin
               we_r <= 1'b0;
               if (i_Busy) begin
                  state_r <= ST_WAIT_DONE;
               end else if (ack_cnt_r == AKW'(ACK_WAIT - 1)) begin
                  timeout_r <= 1'b1;
                  state_r   <= ST_IDLE;
               end else begin
                  ack_cnt_r <= ack_cnt_r + AKW'(1);
               end
            end
            ST_WAIT_DONE: begin
               we_r <= 1'b0;
               if (!i_Busy) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               we_r    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a simple encoder model driving i_Busy.
module tb_uart_tx_queue;
   import uart_tx_queue_pkg::*;

   localparam int DEPTH     = 16;
   localparam int ACK_WAIT  = 4;
   localparam int ENC_FRAME = 20;

   logic        i_Clk = 1'b0;
   logic        i_Rst_L;
   logic [7:0]  i_Byte;
   logic        i_Write;
   logic        i_Busy;
   logic        o_Full;
   logic        o_Empty;
   logic [4:0]  o_Count;
   logic        o_Overflow;
   logic        o_Ack_Timeout;
   logic [7:0]  o_Byte;
   logic        o_Write_Enable;

   logic        enc_busy    = 1'b0;
   logic        hold_busy   = 1'b0;
   bit          enc_respond = 1'b1;
   int          enc_len     = ENC_FRAME;
   int          tests       = 0;
   int          fails       = 0;
   int          launches    = 0;
   int          snap        = 0;
   logic        we_prev     = 1'b0;
   logic [7:0]  exp_q [$];

   assign i_Busy = enc_busy | hold_busy;

   always #5 i_Clk = ~i_Clk;

   uart_tx_queue #(
      .DEPTH    (DEPTH),
      .ACK_WAIT (ACK_WAIT)
   ) dut (
      .i_Clk          (i_Clk),
      .i_Rst_L        (i_Rst_L),
      .i_Byte         (i_Byte),
      .i_Write        (i_Write),
      .o_Full         (o_Full),
      .o_Empty        (o_Empty),
      .o_Count        (o_Count),
      .o_Overflow     (o_Overflow),
      .o_Ack_Timeout  (o_Ack_Timeout),
      .o_Byte         (o_Byte),
      .o_Write_Enable (o_Write_Enable),
      .i_Busy         (i_Busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Launch monitor: every pulse must be single-cycle and carry the next expected byte.
   initial forever begin
      @(negedge i_Clk);
      if (o_Write_Enable) begin
         launches++;
         check_eq("we_pulse_width", 32'(we_prev), 32'd0);
         check_eq("launch_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check_eq("launch_byte", 32'(o_Byte), 32'(exp_q.pop_front()));
         end
      end
      we_prev = o_Write_Enable;
   end

   // Encoder model: raises busy on the launch pulse and holds it for enc_len clocks.
   initial forever begin
      @(negedge i_Clk);
      if (o_Write_Enable && enc_respond) begin
         enc_busy = 1'b1;
         repeat (enc_len) @(negedge i_Clk);
         enc_busy = 1'b0;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic put(input logic [7:0] b, input bit expect_it);
      i_Byte  = b;
      i_Write = 1'b1;
      if (expect_it) exp_q.push_back(b);
      @(negedge i_Clk);
      i_Write = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_count"}, 32'(o_Count), 32'd0);
      check_eq({tag, "_empty"}, 32'(o_Empty), 32'd1);
      check_eq({tag, "_full"},  32'(o_Full), 32'd0);
      check_eq({tag, "_byte"},  32'(o_Byte), 32'h00);
      check_eq({tag, "_we"},    32'(o_Write_Enable), 32'd0);
      check_eq({tag, "_ovf"},   32'(o_Overflow), 32'd0);
      check_eq({tag, "_ato"},   32'(o_Ack_Timeout), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge i_Clk);
      i_Rst_L = 1'b0;
      exp_q.delete();
      repeat (enc_len + 3) @(negedge i_Clk);
      check_reset_values("reset");
      i_Rst_L = 1'b1;
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      for (int pass = 0; pass < 2; pass++) begin
         while ((exp_q.size() != 0 || !o_Empty || i_Busy) && n < 4000) begin
            @(negedge i_Clk);
            n++;
         end
         repeat (2) @(negedge i_Clk);
      end
      check_eq({tag, "_drained_in_time"}, 32'(n < 4000), 32'd1);
   endtask

   initial begin
      i_Rst_L = 1'b0;
      i_Byte  = 8'h00;
      i_Write = 1'b0;

      // Single byte latency
      do_reset();
      put(8'h41, 1'b1);
      check_eq("lat_we_early", 32'(o_Write_Enable), 32'd0);
      @(negedge i_Clk);
      check_eq("lat_we", 32'(o_Write_Enable), 32'd1);
      check_eq("lat_byte", 32'(o_Byte), 32'h41);
      check_eq("lat_count", 32'(o_Count), 32'd0);
      wait_drain("single");

      // Streaming 40 bytes through the 16-deep queue
      do_reset();
      snap = launches;
      for (int i = 0; i < 40; i++) begin
         int n = 0;
         while (o_Full && n < 2000) begin
            @(negedge i_Clk);
            n++;
         end
         put(8'($urandom_range(0, 255)), 1'b1);
      end
      wait_drain("stream");
      check_eq("stream_launches", 32'(launches - snap), 32'd40);
      check_eq("stream_ovf", 32'(o_Overflow), 32'd0);
      check_eq("stream_ato", 32'(o_Ack_Timeout), 32'd0);

      // Fill to full, overflow, then a write coincident with the first pop
      do_reset();
      hold_busy = 1'b1;
      snap = launches;
      for (int i = 0; i < 16; i++) put(8'(i), 1'b1);
      check_eq("fill_full", 32'(o_Full), 32'd1);
      check_eq("fill_count", 32'(o_Count), 32'd16);
      check_eq("fill_ovf", 32'(o_Overflow), 32'd0);
      put(8'hFF, 1'b0);
      check_eq("ovf_set", 32'(o_Overflow), 32'd1);
      check_eq("ovf_full", 32'(o_Full), 32'd1);
      check_eq("ovf_count", 32'(o_Count), 32'd16);
      hold_busy = 1'b0;
      put(8'hEE, 1'b0);
      check_eq("popwr_count", 32'(o_Count), 32'd15);
      check_eq("popwr_ovf", 32'(o_Overflow), 32'd1);
      wait_drain("full");
      check_eq("full_launches", 32'(launches - snap), 32'd16);
      check_eq("full_ovf_sticky", 32'(o_Overflow), 32'd1);

      // Encoder never acknowledges
      do_reset();
      enc_respond = 1'b0;
      snap = launches;
      put(8'hA1, 1'b1);
      put(8'hA2, 1'b1);
      check_eq("ato_first_we", 32'(o_Write_Enable), 32'd1);
      repeat (4) @(negedge i_Clk);
      check_eq("ato_not_yet", 32'(o_Ack_Timeout), 32'd0);
      @(negedge i_Clk);
      check_eq("ato_set", 32'(o_Ack_Timeout), 32'd1);
      @(negedge i_Clk);
      check_eq("ato_next_we", 32'(o_Write_Enable), 32'd1);
      wait_drain("ato");
      check_eq("ato_launches", 32'(launches - snap), 32'd2);
      enc_respond = 1'b1;

      // Reset in WAIT_DONE with 5 bytes queued
      do_reset();
      enc_len = 60;
      for (int i = 0; i < 6; i++) put(8'(8'h30 + i), 1'b1);
      repeat (3) @(negedge i_Clk);
      check_eq("mid_count", 32'(o_Count), 32'd5);
      check_eq("mid_busy", 32'(i_Busy), 32'd1);
      #3;
      i_Rst_L = 1'b0;
      #1;
      check_reset_values("async");
      exp_q.delete();
      snap = launches;
      repeat (enc_len + 5) @(negedge i_Clk);
      i_Rst_L = 1'b1;
      repeat (30) @(negedge i_Clk);
      check_eq("no_launch_after_rst", 32'(launches - snap), 32'd0);
      put(8'h5A, 1'b1);
      wait_drain("post_rst");
      check_eq("post_rst_launches", 32'(launches - snap), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
